// File: rtl/picorv32_mem_pkg.sv
// Shared types for the PicoRV32 memory responder: FSM states, the latched
// request record and the value returned for unmapped reads.
package picorv32_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] OOB_RDATA = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/picorv32_bytewrite_ram.sv
// Single-port word RAM with per-byte write enables; synchronous write,
// asynchronous read. Contents are deliberately not reset.
module picorv32_bytewrite_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/picorv32_mem_responder.sv
// PicoRV32 native-bus memory responder with programmable wait states and a
// sticky write lock guarding the low boot region of the RAM.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for mem_valid; request is taken straight off the bus
//   ST_WAIT | counting down wait states on the latched request
//   ST_RESP | one-cycle mem_ready strobe with rdata and status pulses
module picorv32_mem_responder
    import picorv32_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter int          PROT_WORDS  = 64,
    parameter logic [31:0] LOCK_ADDR   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        lock_o,
    output logic        wr_violation_o,
    output logic        oob_o
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    mem_req_t    req_q, req_cur;
    logic        lock;
    logic [29:0] idx;
    logic        ram_hit, lock_hit, prot_hit, is_wr, commit;
    logic        ram_we, viol, lock_set;
    logic [31:0] ram_rdata, rdata_nxt;
    logic        unused_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = 4'(WAIT_STATES - 1);
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = ST_RESP;
                else                  wait_cnt_nxt = wait_cnt - 4'd1;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          req_q <= '0;
        else if (state == ST_IDLE && mem_valid) req_q <= {mem_addr, mem_wdata, mem_wstrb};
    end

    // With zero wait states the commit edge is the accept edge, so the live
    // bus must be decoded while idle rather than the latched copy.
    assign req_cur  = (state == ST_IDLE) ? mem_req_t'({mem_addr, mem_wdata, mem_wstrb}) : req_q;
    assign idx      = req_cur.addr[31:2];
    assign ram_hit  = {2'b00, idx} < 32'(DEPTH_WORDS);
    assign prot_hit = ram_hit && ({2'b00, idx} < 32'(PROT_WORDS));
    assign lock_hit = {idx, 2'b00} == LOCK_ADDR;
    assign is_wr    = |req_cur.wstrb;
    assign commit   = (state_nxt == ST_RESP);
    assign viol     = commit && is_wr && lock && prot_hit;
    assign ram_we   = commit && is_wr && ram_hit && !viol;
    assign lock_set = commit && lock_hit && req_cur.wstrb[0] && req_cur.wdata[0];

    picorv32_bytewrite_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (req_cur.wstrb),
        .addr  (req_cur.addr[ADDR_W+1:2]),
        .wdata (req_cur.wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        rdata_nxt = '0;
        if (!is_wr) begin
            if (ram_hit)       rdata_nxt = ram_rdata;
            else if (lock_hit) rdata_nxt = {31'b0, lock};
            else               rdata_nxt = OOB_RDATA;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock           <= 1'b0;
            mem_rdata      <= '0;
            wr_violation_o <= 1'b0;
            oob_o          <= 1'b0;
        end else begin
            lock           <= lock | lock_set;
            mem_rdata      <= commit ? rdata_nxt : '0;
            wr_violation_o <= viol;
            oob_o          <= commit && !ram_hit && !lock_hit;
        end
    end

    assign mem_ready = (state == ST_RESP);
    assign lock_o    = lock;
    assign unused_ok = &{1'b0, mem_instr, req_cur.addr[1:0]};

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed scoreboard bench: a 2-wait-state instance for the main checks and a
// zero-wait-state instance for back-to-back timing.
module tb_picorv32_mem_responder;
    import picorv32_mem_pkg::*;

    localparam logic [31:0] LOCK_ADDR = 32'h0001_0000;

    logic        clk, resetn;
    logic        mem_valid, mem_instr, fast_sel;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        valid2, valid0;
    logic        rdy2, rdy0, lock2, lock0, viol2, viol0, oob2, oob0;
    logic [31:0] rd2, rd0;
    logic        rdy, lk, viol, oob;
    logic [31:0] rdata;

    typedef struct { logic [31:0] rd; logic v; logic o; } exp_t;
    exp_t sb_q[$];
    int n_total = 0;
    int n_pass  = 0;

    assign valid2 = mem_valid & ~fast_sel;
    assign valid0 = mem_valid &  fast_sel;
    assign rdy    = fast_sel ? rdy0  : rdy2;
    assign rdata  = fast_sel ? rd0   : rd2;
    assign lk     = fast_sel ? lock0 : lock2;
    assign viol   = fast_sel ? viol0 : viol2;
    assign oob    = fast_sel ? oob0  : oob2;

    picorv32_mem_responder #(.WAIT_STATES(2), .LOCK_ADDR(LOCK_ADDR)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(valid2), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(rdy2), .mem_rdata(rd2), .lock_o(lock2),
        .wr_violation_o(viol2), .oob_o(oob2));

    picorv32_mem_responder #(.WAIT_STATES(0), .LOCK_ADDR(LOCK_ADDR)) dut0 (
        .clk(clk), .resetn(resetn), .mem_valid(valid0), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(rdy0), .mem_rdata(rd0), .lock_o(lock0),
        .wr_violation_o(viol0), .oob_o(oob0));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One complete transaction; expectation is queued at drive time and
    // retired when mem_ready is seen.
    task automatic xact(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] erd,
                        input logic ev, input logic eo);
        int   n;
        bit   got;
        exp_t e;
        sb_q.push_back('{erd, ev, eo});
        @(negedge clk);
        mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_valid = 1'b1;
        @(posedge clk);
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (rdy) begin
                got = 1;
                e = sb_q.pop_front();
                chk({tag, "_rdata"}, rdata, e.rd);
                chk({tag, "_viol"},  32'(viol), 32'(e.v));
                chk({tag, "_oob"},   32'(oob),  32'(e.o));
                chk({tag, "_lat"},   32'(n), fast_sel ? 32'd1 : 32'd3);
                mem_valid = 1'b0;
            end else begin
                chk({tag, "_pulse_early"}, {30'b0, viol, oob}, 32'd0);
            end
        end
        chk({tag, "_timeout"}, 32'(got), 32'd1);
        if (!got) mem_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_1cyc"}, 32'(rdy), 32'd0);
        chk({tag, "_rdata_clr"}, rdata, 32'd0);
        chk({tag, "_pulse_clr"}, {30'b0, viol, oob}, 32'd0);
    endtask

    initial begin
        clk = 0; resetn = 0; mem_valid = 0; mem_instr = 0; fast_sel = 0;
        mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(rdy2), 32'd0);
        chk("rst_rdata", rd2, 32'd0);
        chk("rst_lock",  32'(lock2), 32'd0);
        chk("rst_viol",  32'(viol2), 32'd0);
        chk("rst_oob",   32'(oob2), 32'd0);
        resetn = 1;

        xact("wr5",  32'd5 << 2, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 0);
        xact("wr0",  32'd0,      32'h0BAD_0000, 4'hF, 32'h0, 0, 0);
        xact("rd5",  32'd5 << 2, 32'h0,         4'h0, 32'hCAFE_F00D, 0, 0);

        xact("wr10a", 32'd10 << 2, 32'h0,         4'hF,    32'h0, 0, 0);
        xact("wr10b", 32'd10 << 2, 32'h1122_3344, 4'b0101, 32'h0, 0, 0);
        xact("rd10",  32'd10 << 2, 32'h0,         4'h0,    32'h0022_0044, 0, 0);

        xact("wr3",    32'd3 << 2, 32'hA5A5_0003, 4'hF, 32'h0, 0, 0);
        xact("lock",   LOCK_ADDR,  32'h1,         4'h1, 32'h0, 0, 0);
        chk("lock_set", 32'(lock2), 32'd1);
        xact("rdlock", LOCK_ADDR,  32'h0,         4'h0, 32'h1, 0, 0);
        xact("wr3p",   32'd3 << 2, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 0);
        xact("rd3p",   32'd3 << 2, 32'h0,         4'h0, 32'hA5A5_0003, 0, 0);
        xact("wr64",   32'd64 << 2, 32'h1234_5678, 4'hF, 32'h0, 0, 0);
        xact("rd64",   32'd64 << 2, 32'h0,         4'h0, 32'h1234_5678, 0, 0);
        xact("unlock", LOCK_ADDR,  32'h0,         4'hF, 32'h0, 0, 0);
        chk("lock_sticky", 32'(lock2), 32'd1);

        @(negedge clk);
        resetn = 0;
        #1 chk("lock_rst", 32'(lock2), 32'd0);
        @(negedge clk);
        resetn = 1;
        xact("wr3u", 32'd3 << 2, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0);
        xact("rd3u", 32'd3 << 2, 32'h0,         4'h0, 32'hDEAD_BEEF, 0, 0);

        xact("oobw",  32'h0002_0000, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 1);
        xact("oobr",  32'h0002_0000, 32'h0,         4'h0, 32'h0, 0, 1);
        xact("rd0",   32'd0,         32'h0,         4'h0, 32'h0BAD_0000, 0, 0);

        xact("wr20", 32'd20 << 2, 32'h1111_0000, 4'hF, 32'h0, 0, 0);
        @(negedge clk);
        mem_addr = 32'd20 << 2; mem_wdata = 32'h9999_9999; mem_wstrb = 4'hF; mem_valid = 1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_wait", 32'(dut.state), 32'(ST_WAIT));
        resetn = 0; mem_valid = 0;
        #1;
        chk("abort_ready", 32'(rdy2), 32'd0);
        chk("abort_idle",  32'(dut.state), 32'(ST_IDLE));
        @(negedge clk);
        resetn = 1;
        xact("rd20", 32'd20 << 2, 32'h0, 4'h0, 32'h1111_0000, 0, 0);

        fast_sel = 1;
        xact("f_wr1", 32'd1 << 2, 32'h0101_0101, 4'hF, 32'h0, 0, 0);
        xact("f_wr2", 32'd2 << 2, 32'h0202_0202, 4'hF, 32'h0, 0, 0);
        sb_q.push_back('{32'h0101_0101, 1'b0, 1'b0});
        sb_q.push_back('{32'h0202_0202, 1'b0, 1'b0});
        @(negedge clk);
        mem_addr = 32'd1 << 2; mem_wstrb = 4'h0; mem_valid = 1;
        @(negedge clk);
        chk("b2b_resp1", 32'(rdy), 32'd1);
        if (sb_q.size() > 0) chk("b2b_rd1", rdata, sb_q.pop_front().rd);
        mem_addr = 32'd2 << 2;
        @(negedge clk);
        chk("b2b_idle", 32'(rdy), 32'd0);
        @(negedge clk);
        chk("b2b_resp2", 32'(rdy), 32'd1);
        if (sb_q.size() > 0) chk("b2b_rd2", rdata, sb_q.pop_front().rd);
        mem_valid = 0;
        @(negedge clk);
        chk("b2b_done", 32'(rdy), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
